// File: rtl/count_display_scan.sv
// Four-digit multiplexed common-anode display for the up/down/load counter: decimal count, blank, mode letter, wrap dp.
// Optional LEADING_ZERO_BLANK_EN: blank digit 1 when the tens digit is zero.
module count_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       up_down,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_L     = 7'h47;

  function automatic logic [6:0] enc_digit(input logic [3:0] v);
    case (v)
      4'd0:    enc_digit = 7'h40;
      4'd1:    enc_digit = 7'h79;
      4'd2:    enc_digit = 7'h24;
      4'd3:    enc_digit = 7'h30;
      4'd4:    enc_digit = 7'h19;
      4'd5:    enc_digit = 7'h12;
      4'd6:    enc_digit = 7'h02;
      4'd7:    enc_digit = 7'h78;
      4'd8:    enc_digit = 7'h00;
      4'd9:    enc_digit = 7'h10;
      default: enc_digit = SEG_BLANK;
    endcase
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       scan_q;
  logic [1:0]       up_sync_q, ld_sync_q;
  logic [3:0]       prev_count_q;
  logic             wrap_pend_q, wrap_pend_d;
  logic [3:0]       snap_cnt_q;
  logic             snap_up_q, snap_ld_q, snap_wrap_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       up_s, load_s, tick, frame_end, wrap_evt, tens;
  logic [3:0] units;

  assign up_s      = up_sync_q[1];
  assign load_s    = ld_sync_q[1];
  assign tick      = (div_q == DIV_MAX);
  assign frame_end = tick && (scan_q == 2'd3);
  assign div_d     = tick ? '0 : div_q + 1'b1;

  assign wrap_evt = !load_s &&
                    (( up_s && prev_count_q == 4'd15 && count == 4'd0) ||
                     (!up_s && prev_count_q == 4'd0  && count == 4'd15));

  // A wrap seen on the snapshot edge must survive into the next frame.
  assign wrap_pend_d = frame_end ? wrap_evt : (wrap_pend_q | wrap_evt);

  assign tens  = (snap_cnt_q >= 4'd10);
  assign units = tens ? snap_cnt_q - 4'd10 : snap_cnt_q;

  always_comb begin
    an_d  = ~(4'b0001 << scan_q);
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (scan_q)
      2'd0: begin
        seg_d = enc_digit(units);
        dp_d  = ~snap_wrap_q;
      end
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = tens ? enc_digit(4'd1) : SEG_BLANK;
`else
        seg_d = tens ? enc_digit(4'd1) : enc_digit(4'd0);
`endif
      end
      2'd2:    seg_d = SEG_BLANK;
      default: seg_d = snap_ld_q ? SEG_L : (snap_up_q ? SEG_U : SEG_D);
    endcase
  end

  // NOTE: all state uses non-blocking assignments so the snapshot and the
  // digit-3 pattern latched on the same edge both see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      scan_q       <= 2'd0;
      up_sync_q    <= 2'b00;
      ld_sync_q    <= 2'b00;
      prev_count_q <= 4'd0;
      wrap_pend_q  <= 1'b0;
      snap_cnt_q   <= 4'd0;
      snap_up_q    <= 1'b0;
      snap_ld_q    <= 1'b0;
      snap_wrap_q  <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      div_q        <= div_d;
      up_sync_q    <= {up_sync_q[0], up_down};
      ld_sync_q    <= {ld_sync_q[0], load};
      prev_count_q <= count;
      wrap_pend_q  <= wrap_pend_d;
      if (tick) begin
        scan_q <= scan_q + 2'd1;
        an_q   <= an_d;
        seg_q  <= seg_d;
        dp_q   <= dp_d;
      end
      if (frame_end) begin
        snap_cnt_q  <= count;
        snap_up_q   <= up_s;
        snap_ld_q   <= load_s;
        snap_wrap_q <= wrap_pend_q;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan at REFRESH_DIV=4 (one frame = 16 clocks).
module tb_count_display_scan;

  localparam int REFRESH_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] D1_ZERO = 7'h7F;
`else
  localparam logic [6:0] D1_ZERO = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       up_down, load;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  logic [3:0] cap_an  [4];

  count_display_scan #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .count   (count),
    .up_down (up_down),
    .load    (load),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Returns on the first negedge at which digit 0 has just become active.
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (prev != 4'b1110 && an == 4'b1110) found = 1'b1;
      prev = an;
    end
    if (!found) check("frame_timeout", 8'd0, 8'd1);
  endtask

  task automatic capture_frame();
    wait_frame_start();
    for (int d = 0; d < 4; d++) begin
      if (d != 0) repeat (REFRESH_DIV) @(negedge clk);
      cap_seg[d] = seg;
      cap_dp[d]  = dp;
      cap_an[d]  = an;
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e3, input logic e_dp0);
    check({tag, "_d0"}, {1'b0, cap_seg[0]}, {1'b0, e0});
    check({tag, "_d1"}, {1'b0, cap_seg[1]}, {1'b0, e1});
    check({tag, "_d2"}, {1'b0, cap_seg[2]}, 8'h7F);
    check({tag, "_d3"}, {1'b0, cap_seg[3]}, {1'b0, e3});
    check({tag, "_dp0"}, {7'd0, cap_dp[0]}, {7'd0, e_dp0});
    check({tag, "_dp1"}, {7'd0, cap_dp[1]}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; count = 4'd0; up_down = 1'b0; load = 1'b0;
    #1;
    check("rst_an",  {4'd0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_dp",  {7'd0, dp}, 8'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Count 13, counting up
    count = 4'd13; up_down = 1'b1; load = 1'b0;
    wait_frame_start();
    capture_frame();
    check_frame("up13", 7'h30, 7'h79, 7'h41, 1'b1);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << d);
      check("up13_an", {4'd0, cap_an[d]}, {4'd0, ea});
      check("up13_dp", {7'd0, cap_dp[d]}, 8'd1);
    end
    capture_frame();
    check_frame("up13_f2", 7'h30, 7'h79, 7'h41, 1'b1);

    // Count 7, counting down
    count = 4'd7; up_down = 1'b0;
    wait_frame_start();
    capture_frame();
    check_frame("dn7", 7'h78, D1_ZERO, 7'h21, 1'b1);

    // Load mode on, then off
    load = 1'b1;
    wait_frame_start();
    capture_frame();
    check_frame("ld7", 7'h78, D1_ZERO, 7'h47, 1'b1);
    load = 1'b0;
    wait_frame_start();
    capture_frame();
    check_frame("unld7", 7'h78, D1_ZERO, 7'h21, 1'b1);

    // Up wrap 15 -> 0: dp on digit 0 for exactly one frame
    count = 4'd15; up_down = 1'b1;
    wait_frame_start();
    capture_frame();
    check_frame("up15", 7'h12, 7'h79, 7'h41, 1'b1);
    wait_frame_start();
    count = 4'd0;
    capture_frame();
    check_frame("wrap", 7'h40, D1_ZERO, 7'h41, 1'b0);
    capture_frame();
    check_frame("wrap_after", 7'h40, D1_ZERO, 7'h41, 1'b1);

    // Same transition in load mode must not flag a wrap
    load = 1'b1; count = 4'd15;
    wait_frame_start();
    capture_frame();
    check_frame("ld15", 7'h12, 7'h79, 7'h47, 1'b1);
    wait_frame_start();
    count = 4'd0;
    capture_frame();
    check_frame("ld_wrap", 7'h40, D1_ZERO, 7'h47, 1'b1);

    // Tearing: 9 -> 10 while digit 1 is on
    load = 1'b0; count = 4'd9;
    wait_frame_start();
    capture_frame();
    check_frame("nine", 7'h10, D1_ZERO, 7'h41, 1'b1);
    wait_frame_start();
    repeat (REFRESH_DIV) @(negedge clk);
    count = 4'd10;
    check("tear_an1",  {4'd0, an}, 8'h0D);
    check("tear_seg1", {1'b0, seg}, {1'b0, D1_ZERO});
    repeat (2 * REFRESH_DIV) @(negedge clk);
    check("tear_seg3", {1'b0, seg}, 8'h41);
    capture_frame();
    check_frame("ten", 7'h40, 7'h79, 7'h41, 1'b1);

    // Reset during digit 2
    wait_frame_start();
    repeat (2 * REFRESH_DIV) @(negedge clk);
    check("pre_rst_an", {4'd0, an}, 8'h0B);
    rst = 1'b1;
    #1;
    check("midrst_an",  {4'd0, an}, 8'h0F);
    check("midrst_seg", {1'b0, seg}, 8'h7F);
    check("midrst_dp",  {7'd0, dp}, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (REFRESH_DIV - 1) @(negedge clk);
    check("post_rst_hold_an", {4'd0, an}, 8'h0F);
    @(negedge clk);
    check("post_rst_an",  {4'd0, an}, 8'h0E);
    check("post_rst_seg", {1'b0, seg}, 8'h40);
    check("post_rst_dp",  {7'd0, dp}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
